// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit -- pipeline hazard controller for the SampleCPU core.
//
// Merges per-stage stall requests into a hold vector (the deepest requester
// holds itself and every earlier register), runs a registered flush
// sequencer that redirects the PC, and a sticky watchdog that flags a
// pipeline stalled for WDOG_LIMIT consecutive cycles.
//
// Optional feature macro: CTRL_STALL_CNT_EN
//   defined   -> 32-bit wrapping stall_cycles counter and port exist
//   undefined -> port absent, no counter logic
//
// Ports:
//   clk           in   core clock, all state on rising edge
//   rst           in   synchronous active-high reset
//   stallreq      in   [NUM_STAGES] bit k = stage k requests a bubble (bit 0 ignored)
//   flush_req     in   redirect request, single-cycle pulse
//   flush_pc      in   [PC_W] redirect target, sampled with flush_req
//   stall         out  [NUM_STAGES] bit k = hold register k this cycle
//   flush         out  clear all pipeline registers this cycle (registered)
//   new_pc        out  [PC_W] last latched redirect target
//   wdog_err      out  sticky hung-pipeline flag, cleared only by rst
//   stall_cycles  out  [32] total stalled cycles (CTRL_STALL_CNT_EN only)

module pipe_ctrl_unit #(
  parameter int unsigned NUM_STAGES   = 6,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WDOG_LIMIT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  flush_req,
  input  logic [PC_W-1:0]       flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [PC_W-1:0]       new_pc,
  output logic                  wdog_err
`ifdef CTRL_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned FCNT_W = 4;
  localparam int unsigned WCNT_W = $clog2(WDOG_LIMIT);
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX    = WCNT_W'(WDOG_LIMIT - 1);

  typedef enum logic {
    RUN,
    FLUSH
  } state_e;

  state_e                state_q, state_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic [PC_W-1:0]       new_pc_q, new_pc_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  wdog_q, wdog_d;
  logic [NUM_STAGES-1:0] req_eff;
  logic [NUM_STAGES-1:0] merged;
  logic                  stalled;

  // Bit 0 is the PC itself and never requests a bubble.
  assign req_eff = stallreq & ~NUM_STAGES'(1);

  // Register i holds when any stage at or beyond i requests, which is the
  // same as a thermometer mask up to the deepest requester.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if ((k >= i) && req_eff[k]) begin
          merged[i] = 1'b1;
        end
      end
    end
  end

  assign stall   = (rst || (state_q == FLUSH)) ? '0 : merged;
  assign stalled = |stall;
  assign flush   = (state_q == FLUSH);
  assign new_pc  = new_pc_q;
  assign wdog_err = wdog_q;

  // Flush sequencer: a request in either state (re)latches the target and
  // reloads the cycle count, so back-to-back requests extend the flush.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    new_pc_d = new_pc_q;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          state_d  = FLUSH;
          fcnt_d   = FCNT_RELOAD;
          new_pc_d = flush_pc;
        end
      end
      FLUSH: begin
        if (flush_req) begin
          fcnt_d   = FCNT_RELOAD;
          new_pc_d = flush_pc;
        end else if (fcnt_q == '0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Watchdog: wcnt counts stalled cycles already seen in the current run,
  // so the error sets on the cycle that would make it WDOG_LIMIT.
  always_comb begin
    wcnt_d = '0;
    wdog_d = wdog_q;
    if (stalled) begin
      wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
      if (wcnt_q == WCNT_MAX) begin
        wdog_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      fcnt_q   <= '0;
      new_pc_q <= '0;
      wcnt_q   <= '0;
      wdog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      new_pc_q <= new_pc_d;
      wcnt_q   <= wcnt_d;
      wdog_q   <= wdog_d;
    end
  end

`ifdef CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stalled) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit (NUM_STAGES=6, FLUSH_CYCLES=2,
// WDOG_LIMIT=8) with directed cases and a randomized reference-model run.

module tb_pipe_ctrl_unit;

  localparam int N  = 6;
  localparam int PW = 32;
  localparam int FC = 2;
  localparam int WL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  stallreq = '0;
  logic          flush_req = 1'b0;
  logic [PW-1:0] flush_pc = '0;
  logic [N-1:0]  stall;
  logic          flush;
  logic [PW-1:0] new_pc;
  logic          wdog_err;
`ifdef CTRL_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_left = 0;   // flush cycles still to show
  logic [31:0] m_pc   = '0;
  int          m_run  = 0;   // consecutive stalled cycles
  bit          m_err  = 1'b0;
  logic [31:0] m_cnt  = '0;

  pipe_ctrl_unit #(
    .NUM_STAGES  (N),
    .PC_W        (PW),
    .FLUSH_CYCLES(FC),
    .WDOG_LIMIT  (WL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stallreq (stallreq),
    .flush_req(flush_req),
    .flush_pc (flush_pc),
    .stall    (stall),
    .flush    (flush),
    .new_pc   (new_pc),
    .wdog_err (wdog_err)
`ifdef CTRL_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Deepest requesting stage k holds registers 0..k.
  function automatic logic [N-1:0] exp_stall();
    int k = -1;
    for (int i = 1; i < N; i++) if (stallreq[i]) k = i;
    if (rst || (m_left > 0) || (k < 0)) return '0;
    return N'((1 << (k + 1)) - 1);
  endfunction

  task automatic drive(input bit r, input logic [N-1:0] req, input bit fr, input logic [31:0] pc);
    rst = r; stallreq = req; flush_req = fr; flush_pc = pc;
    #2;
  endtask

  task automatic tick();
    logic [N-1:0] s;
    @(posedge clk);
    s = exp_stall();
    if (rst) begin
      m_left = 0; m_pc = '0; m_run = 0; m_err = 1'b0; m_cnt = '0;
    end else begin
      if (s != '0) begin
        m_run++;
        if (m_run >= WL) m_err = 1'b1;
        m_cnt++;
      end else begin
        m_run = 0;
      end
      if (flush_req) begin
        m_left = FC; m_pc = flush_pc;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, '0, 1'b0, '0); tick();
    drive(1'b1, '0, 1'b0, '0); tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 6'b101010, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if (stall !== 6'b000000) begin
      errors++; $display("FAIL reset_stall_forced: got %b want 000000", stall);
    end
    tick();
    drive(1'b1, '0, 1'b0, '0); tick();
    drive(1'b0, '0, 1'b0, '0);
    checks++;
    if ({stall, flush, new_pc, wdog_err} !== {6'b0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: stall=%b flush=%b new_pc=%h wdog=%b want all zero",
               stall, flush, new_pc, wdog_err);
    end
    tick();
  endtask

  task automatic test_stall_merge();
    logic [N-1:0] req_t [5] = '{6'b000100, 6'b001100, 6'b000001, 6'b100000, 6'b000010};
    logic [N-1:0] exp_t [5] = '{6'b000111, 6'b001111, 6'b000000, 6'b111111, 6'b000011};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, req_t[i], 1'b0, '0);
      checks++;
      if (stall !== exp_t[i]) begin
        errors++; $display("FAIL merge_%0d: req=%b got %b want %b", i, req_t[i], stall, exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b0, 6'b001000, 1'b1, 32'hBFC0_0380);
    checks++;
    if (stall !== 6'b001111) begin
      errors++; $display("FAIL flush_req_cycle_stall: got %b want 001111", stall);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 6'b001000, 1'b0, 32'h1111_1111);
      checks++;
      if ({flush, stall, new_pc} !== {1'b1, 6'b000000, 32'hBFC0_0380}) begin
        errors++;
        $display("FAIL flush_cycle_%0d: flush=%b stall=%b new_pc=%h want 1 000000 bfc00380",
                 c, flush, stall, new_pc);
      end
      tick();
    end
    drive(1'b0, 6'b001000, 1'b0, '0);
    checks++;
    if ({flush, stall, new_pc} !== {1'b0, 6'b001111, 32'hBFC0_0380}) begin
      errors++;
      $display("FAIL flush_end: flush=%b stall=%b new_pc=%h want 0 001111 bfc00380",
               flush, stall, new_pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic        fl_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] pc_t [4] = '{32'h100, 32'h200, 32'h200, 32'h200};
    do_reset();
    drive(1'b0, '0, 1'b1, 32'h100); tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, (c == 0), 32'h200);
      checks++;
      if ({flush, new_pc} !== {fl_t[c], pc_t[c]}) begin
        errors++;
        $display("FAIL b2b_cycle_%0d: flush=%b new_pc=%h want %b %h", c, flush, new_pc, fl_t[c], pc_t[c]);
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 6'b001000, 1'b0, '0);
      checks++;
      if (wdog_err !== 1'b0) begin
        errors++; $display("FAIL wdog_early_%0d: got %b want 0", c, wdog_err);
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b0, '0);
      checks++;
      if (wdog_err !== 1'b1) begin
        errors++; $display("FAIL wdog_sticky_%0d: got %b want 1", c, wdog_err);
      end
      tick();
    end
    do_reset();
    drive(1'b0, '0, 1'b0, '0);
    checks++;
    if (wdog_err !== 1'b0) begin
      errors++; $display("FAIL wdog_rst_clear: got %b want 0", wdog_err);
    end
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, (c == 7) ? 6'b000000 : 6'b000100, 1'b0, '0);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
    checks++;
    if (wdog_err !== 1'b0) begin
      errors++; $display("FAIL wdog_7_gap_7: got %b want 0", wdog_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    drive(1'b0, '0, 1'b1, 32'h0000_1234); tick();
    drive(1'b1, 6'b010000, 1'b0, '0);
    checks++;
    if ({flush, new_pc, stall} !== {1'b1, 32'h1234, 6'b0}) begin
      errors++; $display("FAIL midflush_pre: flush=%b new_pc=%h stall=%b want 1 00001234 000000", flush, new_pc, stall);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    checks++;
    if ({flush, new_pc} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL midflush_rst: flush=%b new_pc=%h want 0 00000000", flush, new_pc);
    end
    tick();
`ifdef CTRL_STALL_CNT_EN
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 6'b000010, 1'b0, '0); tick();
    end
    drive(1'b0, '0, 1'b0, '0);
    checks++;
    if (stall_cycles !== 32'd5) begin
      errors++; $display("FAIL stall_cycles_5: got %0d want 5", stall_cycles);
    end
    tick();
`endif
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      drive(($urandom_range(0, 60) == 0), req, ($urandom_range(0, 7) == 0), $urandom);
      checks++;
      if ({stall, flush, new_pc, wdog_err} !== {exp_stall(), (m_left > 0), m_pc, m_err}) begin
        errors++;
        $display("FAIL random_%0d: stall=%b flush=%b new_pc=%h wdog=%b want %b %b %h %b",
                 c, stall, flush, new_pc, wdog_err, exp_stall(), (m_left > 0), m_pc, m_err);
      end
`ifdef CTRL_STALL_CNT_EN
      checks++;
      if (stall_cycles !== m_cnt) begin
        errors++; $display("FAIL random_cnt_%0d: got %0d want %0d", c, stall_cycles, m_cnt);
      end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stall_merge();
    test_flush();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
